// File: rtl/calc_pkg.sv
// Shared types and ASCII constants for the calculator command sequencer.
package calc_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_SP1, S_MODE, S_SP2, S_OPA, S_OPR, S_OPB, S_EQ, S_EXEC, S_TX, S_ERR
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [7:0] CH_I     = 8'h49;
    localparam logic [7:0] CH_U     = 8'h55;
    localparam logic [7:0] CH_S     = 8'h53;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_STAR  = 8'h2A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_E     = 8'h45;
    localparam logic [7:0] CH_0     = 8'h30;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    function automatic logic is_op(input logic [7:0] b);
        return (b == CH_PLUS) || (b == CH_MINUS) || (b == CH_STAR) || (b == CH_SLASH);
    endfunction

    function automatic logic [1:0] op_of(input logic [7:0] b);
        case (b)
            CH_MINUS: return OP_SUB;
            CH_STAR:  return OP_MUL;
            CH_SLASH: return OP_DIV;
            default:  return OP_ADD;
        endcase
    endfunction
endpackage

// File: rtl/calc_cmd_seq_if.sv
// UART-side byte stream: receive strobe in, transmit valid/ready out.
interface calc_cmd_seq_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       rx_drop;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid, rx_drop);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid, rx_drop);
endinterface

// File: rtl/calc_tx_fmt.sv
// Serialises a latched sign/BCD result (or the error reply) as ASCII over valid/ready.
module calc_tx_fmt
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        err,
    input  logic        sign_en,
    input  logic        neg,
    input  logic [19:0] res,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        done
);
    // idx: 0 sign, 1..5 digits MSD first, 6 CR, 7 'E' (which is followed by CR)
    logic [2:0] idx;
    logic [2:0] first_idx;
    logic [2:0] next_idx;

    function automatic logic [7:0] char_at(input logic [2:0] i);
        case (i)
            3'd0:    return neg ? CH_MINUS : CH_PLUS;
            3'd1:    return CH_0 | {4'h0, res[19:16]};
            3'd2:    return CH_0 | {4'h0, res[15:12]};
            3'd3:    return CH_0 | {4'h0, res[11:8]};
            3'd4:    return CH_0 | {4'h0, res[7:4]};
            3'd5:    return CH_0 | {4'h0, res[3:0]};
            3'd6:    return CH_CR;
            default: return CH_E;
        endcase
    endfunction

    assign first_idx = err ? 3'd7 : (sign_en ? 3'd0 : 3'd1);
    assign next_idx  = (idx == 3'd7) ? 3'd6 : idx + 3'd1;
    assign done      = tx_valid && tx_ready && (idx == 3'd6);

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            idx      <= 3'd0;
        end else if (start) begin
            tx_valid <= 1'b1;
            idx      <= first_idx;
            tx_data  <= char_at(first_idx);
        end else if (tx_valid && tx_ready) begin
            if (idx == 3'd6) begin
                tx_valid <= 1'b0;
            end else begin
                idx     <= next_idx;
                tx_data <= char_at(next_idx);
            end
        end
    end
endmodule

// File: rtl/calc_cmd_seq.sv
// Parses "I <U|S> aaaa<op>bbbb=" commands, launches the ALU and returns the result as ASCII.
module calc_cmd_seq
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    calc_cmd_seq_if.slave           uart,
    output logic [4*NUM_DIGITS-1:0] opa_bcd,
    output logic [4*NUM_DIGITS-1:0] opb_bcd,
    output logic [1:0]              op_code,
    output logic                    signed_mode,
    output logic                    alu_start,
    input  logic                    alu_done,
    input  logic [19:0]             alu_res_bcd,
    input  logic                    alu_neg
);
    localparam int CW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_DIGITS - 1);

    state_t      state;
    logic [CW-1:0] cnt;
    logic [19:0] res_q;
    logic        neg_q;
    logic        fmt_start;
    logic        fmt_done;
    logic [7:0]  fmt_data;
    logic        fmt_valid;
    logic        rxv;
    logic [7:0]  rxd;

    assign rxv = uart.rx_valid;
    assign rxd = uart.rx_data;
    assign uart.tx_data  = fmt_data;
    assign uart.tx_valid = fmt_valid;
    assign uart.rx_drop  = rxv && (state == S_EXEC || state == S_TX || state == S_ERR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            opa_bcd     <= '0;
            opb_bcd     <= '0;
            op_code     <= OP_ADD;
            signed_mode <= 1'b0;
            res_q       <= '0;
            neg_q       <= 1'b0;
            alu_start   <= 1'b0;
            fmt_start   <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            fmt_start <= 1'b0;
            case (state)
                S_IDLE: if (rxv && rxd == CH_I) begin
                    state <= S_SP1;
                    cnt   <= '0;
                end
                S_SP1: if (rxv) begin
                    state <= (rxd == CH_SP) ? S_MODE : S_ERR;
                    fmt_start <= (rxd != CH_SP);
                end
                S_MODE: if (rxv) begin
                    if (rxd == CH_U || rxd == CH_S) begin
                        signed_mode <= (rxd == CH_S);
                        state       <= S_SP2;
                    end else begin
                        state     <= S_ERR;
                        fmt_start <= 1'b1;
                    end
                end
                S_SP2: if (rxv) begin
                    state <= (rxd == CH_SP) ? S_OPA : S_ERR;
                    fmt_start <= (rxd != CH_SP);
                end
                S_OPA, S_OPB: if (rxv) begin
                    if (is_digit(rxd)) begin
                        if (state == S_OPA) opa_bcd <= {opa_bcd[4*NUM_DIGITS-5:0], rxd[3:0]};
                        else                opb_bcd <= {opb_bcd[4*NUM_DIGITS-5:0], rxd[3:0]};
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= (state == S_OPA) ? S_OPR : S_EQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        state     <= S_ERR;
                        fmt_start <= 1'b1;
                    end
                end
                S_OPR: if (rxv) begin
                    if (is_op(rxd)) begin
                        op_code <= op_of(rxd);
                        state   <= S_OPB;
                    end else begin
                        state     <= S_ERR;
                        fmt_start <= 1'b1;
                    end
                end
                S_EQ: if (rxv) begin
                    if (rxd == CH_EQ) begin
                        state     <= S_EXEC;
                        alu_start <= 1'b1;
                    end else begin
                        state     <= S_ERR;
                        fmt_start <= 1'b1;
                    end
                end
                S_EXEC: if (alu_done) begin
                    res_q     <= alu_res_bcd;
                    neg_q     <= alu_neg;
                    state     <= S_TX;
                    fmt_start <= 1'b1;
                end
                S_TX, S_ERR: if (fmt_done) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    calc_tx_fmt u_fmt (
        .clk      (clk),
        .rst      (rst),
        .start    (fmt_start),
        .err      (state == S_ERR),
        .sign_en  (signed_mode),
        .neg      (neg_q),
        .res      (res_q),
        .tx_ready (uart.tx_ready),
        .tx_data  (fmt_data),
        .tx_valid (fmt_valid),
        .done     (fmt_done)
    );
endmodule

// File: doc/calc_cmd_seq.md
CALC_CMD_SEQ -- requirements
Module: calc_cmd_seq

Interface
REQ-001 Parameter NUM_DIGITS, default 4, decimal digits per operand.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 rx_data  in  8  byte from the UART receiver.
REQ-005 rx_valid  in  1  one-cycle strobe; rx_data is valid.
REQ-006 opa_bcd  out  4*NUM_DIGITS  operand A, packed BCD, most significant digit first as received.
REQ-007 opb_bcd  out  4*NUM_DIGITS  operand B, packed BCD.
REQ-008 op_code  out  2  operation: 0 add '+', 1 sub '-', 2 mul '*', 3 div '/'.
REQ-009 signed_mode  out  1  1 for mode 'S', 0 for mode 'U'.
REQ-010 alu_start  out  1  one-cycle pulse that launches the ALU.
REQ-011 alu_done  in  1  one-cycle strobe; result is valid.
REQ-012 alu_res_bcd  in  20  result magnitude, 5 BCD digits.
REQ-013 alu_neg  in  1  result is negative; valid with alu_done.
REQ-014 tx_data  out  8  ASCII byte to the UART transmitter.
REQ-015 tx_valid  out  1  tx_data is offered.
REQ-016 tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high.
REQ-017 rx_drop  out  1  one-cycle pulse when an rx byte is discarded during EXEC or TX.

Function
REQ-018 The command grammar is 'I' SP ('U'|'S') SP digit{NUM_DIGITS} op digit{NUM_DIGITS} '='.
- SP = 0x20; digits are 0x30-0x39; op is one of 0x2B, 0x2D, 0x2A, 0x2F; '=' = 0x3D.
REQ-019 FSM states: IDLE, SP1, MODE, SP2, OPA, OPR, OPB, EQ, EXEC, TX, ERR.
- IDLE waits for 'I'; all other bytes are silently ignored in IDLE.
REQ-020 Each parse state advances only on rx_valid with an accepted byte.
- Any other byte goes to ERR.
REQ-021 OPA and OPB shift each digit in from the right: bcd <= {bcd[4*NUM_DIGITS-5:0], rx_data[3:0]}.
- A digit counter wraps to 0 after NUM_DIGITS digits and advances the state to OPR or EQ.
REQ-022 An op byte in OPR latches op_code.
- The mode byte in MODE latches signed_mode.
- Operands and op_code hold stable from EQ until the next 'I' is accepted.
REQ-023 On '=' in EQ the FSM enters EXEC and asserts alu_start for exactly one cycle, on the cycle after the '=' strobe.
REQ-024 EXEC waits for alu_done with no timeout.
- On alu_done, result and sign are latched and the FSM enters TX.
- alu_done outside EXEC is ignored.
REQ-025 TX byte order:
- a sign char only when signed_mode is 1: '-' if alu_neg, else '+';
- then the 5 result digits, most significant first, as 0x30|digit, leading zeros kept;
- then CR (0x0D).
REQ-026 tx_valid rises the cycle after entry to TX.
- tx_data is held stable while tx_valid && !tx_ready.
- The next byte is presented on the cycle after acceptance, with no bubble required.
REQ-027 After CR is accepted, tx_valid drops and the FSM returns to IDLE.
REQ-028 ERR transmits 'E' then CR under the same handshake, then returns to IDLE; operands are not cleared.
REQ-029 An rx_valid during EXEC, TX or ERR discards the byte and pulses rx_drop in the same cycle.
REQ-030 If rx_valid and alu_done arrive in the same cycle in EXEC, the result is latched and the byte is dropped.

Reset
REQ-031 With rst high at a clock edge, on the next cycle:
- the state is IDLE;
- opa_bcd, opb_bcd, op_code, signed_mode, the latched result and the counters are 0;
- alu_start, tx_valid and rx_drop are 0;
- tx_data is 0x00.
REQ-032 Reset mid-parse, mid-EXEC or mid-TX abandons the command.
- A byte in flight on tx is withdrawn (tx_valid low).
- A later alu_done is ignored.

Structure
REQ-033 A shared package calc_pkg holds:
- the state enum;
- the op_code encodings;
- the ASCII constants (I, U, S, SP, =, +, -, *, /, CR, E, '0').
REQ-034 One sub-module, calc_tx_fmt, converts the latched sign/BCD result into the ASCII byte sequence with the valid/ready handshake.
- The parser FSM stays in calc_cmd_seq.

Verification
REQ-035 Bytes "I U 0004+0008=" -> opa_bcd=0x0004, opb_bcd=0x0008, op_code=0, signed_mode=0, one alu_start pulse.
- Drive alu_res_bcd=0x00012, neg=0 -> tx "00012\r".
REQ-036 Bytes "I S 0004-0002=" -> op_code=1, signed_mode=1.
- alu_res_bcd=0x00002, neg=0 -> tx "+00002\r".
- Repeat with neg=1 -> tx "-00002\r".
REQ-037 Bytes "I S 1234+4567=" with tx_ready low for 7 cycles per byte.
- alu_res_bcd=0x05801 -> tx "+05801\r".
- tx_data is stable while stalled, and each byte is accepted exactly once.
REQ-038 Bytes "I X" -> tx "E\r", no alu_start, return to IDLE.
- A following "I U 0001+0001=" parses normally.
REQ-039 Extra bytes during EXEC/TX -> rx_drop pulses once per byte; output unchanged.
REQ-040 rst asserted after the 3rd digit of operand A -> all outputs reach reset values next cycle.
- A fresh full command completes correctly.
